logic_unit_pipe: RTL and testbench

- Parametrised successor to the team's single-bit AND gate: a WIDTH-bit bitwise logic unit with eight selectable operations.
- Has an optional accumulator mode, where the operation folds operand A into an internal register.
- Has one registered output stage with valid/ready flow control.
- Sits between operand producers and downstream consumers in the datapath; used as the standard logic primitive in new designs.

---
 rtl/logic_unit_pkg.sv | 40 ++++
 rtl/logic_unit_core.sv | 36 +++
 rtl/logic_unit_pipe.sv | 79 +++++++
 tb/tb_logic_unit_pipe.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the bitwise logic unit: operation encoding and the
// reference bitwise operation used by the datapath.
package logic_unit_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_ANDN = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    // Widest operand the shared function handles; callers zero-extend and truncate.
    localparam int MAX_WIDTH = 64;

    function automatic logic [MAX_WIDTH-1:0] logic_apply(
        input op_e                  op,
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b
    );
        logic [MAX_WIDTH-1:0] r;
        r = a;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            OP_ANDN: r = a & ~b;
            OP_PASS: r = a;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_unit_core.sv
// Purely combinational WIDTH-bit logic operation with zero / all-ones flags.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ones
);

    logic [MAX_WIDTH-1:0] a_ext;
    logic [MAX_WIDTH-1:0] b_ext;
    logic [MAX_WIDTH-1:0] res;
    logic                 unused_hi;

    // NOTE: combinational blocks use blocking assignments, and every variable
    // gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        a_ext             = '0;
        b_ext             = '0;
        a_ext[WIDTH-1:0]  = a;
        b_ext[WIDTH-1:0]  = b;
        res               = logic_apply(op_e'(op), a_ext, b_ext);
    end

    assign y         = res[WIDTH-1:0];
    assign zero      = (y == '0);
    assign ones      = &y;
    // Upper bits of the widened result are don't-care (inverting ops set them).
    assign unused_hi = ^res;

endmodule

// File: rtl/logic_unit_pipe.sv
// WIDTH-bit bitwise logic unit with optional accumulator and one registered
// valid/ready output stage (1-cycle latency, full throughput).
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] ACC_RST = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_ones,
    output logic [WIDTH-1:0] acc_q
);

    logic             accept;
    logic             transfer;
    logic [WIDTH-1:0] acc_eff;
    logic [WIDTH-1:0] opnd_b;
    logic [WIDTH-1:0] res_y;
    logic             res_zero;
    logic             res_ones;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign transfer = out_valid && out_ready;

    // A same-cycle clear is applied before the accumulate operation.
    assign acc_eff  = acc_clr ? ACC_RST : acc_q;
    assign opnd_b   = in_acc ? acc_eff : in_b;

    logic_unit_core #(.WIDTH(WIDTH)) u_core (
        .op   (in_op),
        .a    (in_a),
        .b    (opnd_b),
        .y    (res_y),
        .zero (res_zero),
        .ones (res_ones)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_y     <= '0;
            out_zero  <= 1'b0;
            out_ones  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_y     <= res_y;
            out_zero  <= res_zero;
            out_ones  <= res_ones;
        end else if (transfer) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= ACC_RST;
        end else if (accept && in_acc) begin
            acc_q <= res_y;
        end else if (acc_clr) begin
            acc_q <= ACC_RST;
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe (WIDTH=8, ACC_RST=0) with a
// result scoreboard and an independent per-bit truth-table model.
module tb_logic_unit_pipe;
    import logic_unit_pkg::*;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_op;
    logic       in_acc;
    logic       acc_clr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic       out_zero;
    logic       out_ones;
    logic [7:0] acc_q;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] sb[$];

    logic_unit_pipe #(.WIDTH(8), .ACC_RST(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_acc    (in_acc),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_zero  (out_zero),
        .out_ones  (out_ones),
        .acc_q     (acc_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Truth table per op, indexed by {a_bit, b_bit}.
    function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [3:0] tt;
        logic [7:0] r;
        case (op)
            3'd0:    tt = 4'b1000;
            3'd1:    tt = 4'b1110;
            3'd2:    tt = 4'b0110;
            3'd3:    tt = 4'b0111;
            3'd4:    tt = 4'b0001;
            3'd5:    tt = 4'b1001;
            3'd6:    tt = 4'b0100;
            default: tt = 4'b1100;
        endcase
        for (int i = 0; i < 8; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    // Output monitor: every transfer pops and compares one scoreboard entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd0, 32'd1);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                check("out_y", out_y, e);
                check("out_zero", out_zero, e == 8'h00);
                check("out_ones", out_ones, &e);
            end
        end
    end

    // Present one beat (called at posedge+1), wait for acceptance, verify latency.
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic acc, input logic clr, input logic [7:0] exp_y,
                        output int waits);
        logic got;
        got      = 1'b0;
        waits    = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_acc   = acc;
        acc_clr  = clr;
        while (!got && waits < 20) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp_y);
                got = 1'b1;
            end else begin
                waits++;
            end
        end
        if (!got) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_acc   = 1'b0;
        acc_clr  = 1'b0;
        if (got) begin
            check("lat_valid", out_valid, 1'b1);
            check("lat_y", out_y, exp_y);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] sweep_exp [8];
        int         w;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [2:0] rop;

        sweep_exp = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h30, 8'hF0};
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        in_acc    = 1'b0;
        acc_clr   = 1'b0;
        out_ready = 1'b1;

        #12;
        check("rst_valid", out_valid, 1'b0);
        check("rst_y", out_y, 8'h00);
        check("rst_zero", out_zero, 1'b0);
        check("rst_ones", out_ones, 1'b0);
        check("rst_acc", acc_q, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Truth sweep, back-to-back.
        for (int i = 0; i < 8; i++) begin
            send(3'(i), 8'hF0, 8'hCC, 1'b0, 1'b0, sweep_exp[i], w);
            check("sweep_no_bubble", w, 0);
        end

        // Flags.
        send(OP_AND, 8'h0F, 8'hF0, 1'b0, 1'b0, 8'h00, w);
        check("flag_zero_now", out_zero, 1'b1);
        send(OP_OR, 8'h0F, 8'hF0, 1'b0, 1'b0, 8'hFF, w);
        check("flag_ones_now", out_ones, 1'b1);
        idle(1);

        // Backpressure.
        out_ready = 1'b0;
        send(OP_XOR, 8'hAA, 8'hFF, 1'b0, 1'b0, 8'h55, w);
        in_valid = 1'b1;
        in_op    = OP_AND;
        in_a     = 8'h0F;
        in_b     = 8'hF0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1'b1);
            check("bp_y", out_y, 8'h55);
            check("bp_in_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        check("bp_hold_y", out_y, 8'h55);
        out_ready = 1'b1;
        send(OP_AND, 8'h0F, 8'hF0, 1'b0, 1'b0, 8'h00, w);
        check("bp_release_same_cycle", w, 0);

        // Accumulate.
        in_valid = 1'b0;
        acc_clr  = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        check("acc_clear", acc_q, 8'h00);
        send(OP_OR, 8'h01, 8'hA5, 1'b1, 1'b0, 8'h01, w);
        check("acc_q_01", acc_q, 8'h01);
        send(OP_OR, 8'h02, 8'h5A, 1'b1, 1'b0, 8'h03, w);
        check("acc_q_03", acc_q, 8'h03);
        send(OP_OR, 8'h04, 8'hFF, 1'b1, 1'b0, 8'h07, w);
        check("acc_q_07", acc_q, 8'h07);
        send(OP_XOR, 8'hFF, 8'h00, 1'b1, 1'b0, 8'hF8, w);
        check("acc_q_f8", acc_q, 8'hF8);
        send(OP_XOR, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h07, w);
        check("acc_q_back_07", acc_q, 8'h07);

        // Clear collisions.
        send(OP_AND, 8'hFF, 8'h00, 1'b1, 1'b1, 8'h00, w);
        check("clr_and_acc", acc_q, 8'h00);
        send(OP_OR, 8'h5A, 8'h00, 1'b1, 1'b1, 8'h5A, w);
        check("clr_or_acc", acc_q, 8'h5A);
        send(OP_OR, 8'h0F, 8'hF0, 1'b0, 1'b1, 8'hFF, w);
        check("clr_non_acc", acc_q, 8'h00);

        // Random non-accumulate beats, back-to-back.
        for (int i = 0; i < 16; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = 3'($urandom_range(0, 7));
            send(rop, ra, rb, 1'b0, 1'b0, ref_op(rop, ra, rb), w);
            check("rand_no_bubble", w, 0);
        end
        check("rand_acc_untouched", acc_q, 8'h00);
        idle(1);

        // Async reset while stalled.
        out_ready = 1'b0;
        send(OP_OR, 8'h3C, 8'h00, 1'b1, 1'b0, 8'h3C, w);
        check("pre_rst_acc", acc_q, 8'h3C);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_acc", acc_q, 8'h00);
        check("async_rst_y", out_y, 8'h00);
        sb.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        send(OP_AND, 8'hF0, 8'hCC, 1'b0, 1'b0, 8'hC0, w);
        check("post_rst_no_bubble", w, 0);
        check("post_rst_acc", acc_q, 8'h00);
        idle(2);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
